// File: rtl/axis_bubble_sorter_pkg.sv
// Shared types and constants for the AXI-Stream bubble sorter.
package axis_bubble_sorter_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } sort_state_t;

    function automatic int num_elems(input int addr_width);
        return 1 << addr_width;
    endfunction

    localparam int DEF_ADDR_WIDTH = 2;
    localparam int NUM_ELEMS      = num_elems(DEF_ADDR_WIDTH);

endpackage

// File: rtl/axis_sort_cmp_swap.sv
// Combinational compare-swap of two unsigned words; ties keep their order.
module axis_sort_cmp_swap #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi,
    output logic                  swapped
);

    assign swapped = a > b;
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

endmodule

// File: rtl/axis_bubble_sorter.sv
// Buffers one AXI-Stream frame, bubble-sorts it in place (one compare-swap
// per cycle) and streams it back out in ascending unsigned order.
module axis_bubble_sorter
    import axis_bubble_sorter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_tvalid,
    output logic                  src_tready,
    input  logic [DATA_WIDTH-1:0] src_tdata,
    input  logic                  src_tlast,
    output logic                  dest_tvalid,
    input  logic                  dest_tready,
    output logic [DATA_WIDTH-1:0] dest_tdata,
    output logic                  dest_tlast
);

    localparam int                  N       = num_elems(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = ADDR_WIDTH'(N - 1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_TWO = (ADDR_WIDTH+1)'(2);

    sort_state_t           state;
    logic [DATA_WIDTH-1:0] mem [N];
    logic [ADDR_WIDTH-1:0] count;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] idx_nxt;
    logic [ADDR_WIDTH-1:0] rd;
    logic [ADDR_WIDTH:0]   len;
    logic                  pass_swapped;

    logic [DATA_WIDTH-1:0] cmp_lo;
    logic [DATA_WIDTH-1:0] cmp_hi;
    logic                  cmp_swap;
    logic                  src_hs;
    logic                  dst_hs;
    logic                  frame_end;
    logic                  last_cmp;
    logic                  last_rd;
    logic                  do_swap;

    axis_sort_cmp_swap #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
        .a       (mem[idx]),
        .b       (mem[idx_nxt]),
        .lo      (cmp_lo),
        .hi      (cmp_hi),
        .swapped (cmp_swap)
    );

    assign idx_nxt     = idx + 1'b1;
    assign src_tready  = rst && (state == FILL);
    assign src_hs      = src_tvalid && src_tready;
    assign dst_hs      = dest_tvalid && dest_tready;
    // A full buffer closes the frame even without tlast.
    assign frame_end   = src_hs && (src_tlast || (count == CNT_MAX));
    assign last_cmp    = ({1'b0, idx} == (len - LEN_TWO));
    assign last_rd     = ({1'b0, rd} == (len - LEN_ONE));
    assign do_swap     = rst && (state == SORT) && (len != LEN_ONE) && cmp_swap;
    assign dest_tdata  = mem[rd];
    assign dest_tlast  = dest_tvalid && last_rd;

    // Data buffer carries no reset; control state alone decides validity.
    always_ff @(posedge clk) begin
        if (src_hs) begin
            mem[count] <= src_tdata;
        end else if (do_swap) begin
            mem[idx]     <= cmp_lo;
            mem[idx_nxt] <= cmp_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= FILL;
            count        <= '0;
            idx          <= '0;
            rd           <= '0;
            len          <= '0;
            pass_swapped <= 1'b0;
            dest_tvalid  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (src_hs) begin
                        count <= count + 1'b1;
                        if (frame_end) begin
                            len          <= {1'b0, count} + LEN_ONE;
                            count        <= '0;
                            idx          <= '0;
                            pass_swapped <= 1'b0;
                            state        <= SORT;
                        end
                    end
                end
                SORT: begin
                    if (len == LEN_ONE) begin
                        rd          <= '0;
                        dest_tvalid <= 1'b1;
                        state       <= DRAIN;
                    end else if (last_cmp) begin
                        // A clean pass means the buffer is ordered.
                        if (pass_swapped || cmp_swap) begin
                            idx          <= '0;
                            pass_swapped <= 1'b0;
                        end else begin
                            rd          <= '0;
                            dest_tvalid <= 1'b1;
                            state       <= DRAIN;
                        end
                    end else begin
                        idx          <= idx_nxt;
                        pass_swapped <= pass_swapped || cmp_swap;
                    end
                end
                DRAIN: begin
                    if (dst_hs) begin
                        rd <= rd + 1'b1;
                        if (last_rd) begin
                            rd          <= '0;
                            dest_tvalid <= 1'b0;
                            state       <= FILL;
                        end
                    end
                end
                default: begin
                    dest_tvalid <= 1'b0;
                    state       <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_bubble_sorter.sv
// Directed bench for axis_bubble_sorter with hand-computed sorted frames.
module tb_axis_bubble_sorter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       src_tvalid = 1'b0;
    logic       src_tready;
    logic [7:0] src_tdata = '0;
    logic       src_tlast = 1'b0;
    logic       dest_tvalid;
    logic       dest_tready = 1'b0;
    logic [7:0] dest_tdata;
    logic       dest_tlast;

    int n_cmp = 0;
    int n_err = 0;

    axis_bubble_sorter #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_tvalid  (src_tvalid),
        .src_tready  (src_tready),
        .src_tdata   (src_tdata),
        .src_tlast   (src_tlast),
        .dest_tvalid (dest_tvalid),
        .dest_tready (dest_tready),
        .dest_tdata  (dest_tdata),
        .dest_tlast  (dest_tlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic push(input logic [7:0] d, input bit last);
        int t;
        t = 0;
        src_tvalid = 1'b1;
        src_tdata  = d;
        src_tlast  = last;
        while (!src_tready && t < 300) begin
            step();
            t++;
        end
        chk("push_wait", {31'd0, src_tready}, 32'd1);
        step();
        src_tvalid = 1'b0;
        src_tlast  = 1'b0;
    endtask

    task automatic pull(output logic [7:0] d, output bit l);
        int t;
        t = 0;
        dest_tready = 1'b1;
        while (!dest_tvalid && t < 300) begin
            step();
            t++;
        end
        chk("pull_wait", {31'd0, dest_tvalid}, 32'd1);
        d = dest_tdata;
        l = dest_tlast;
        step();
        dest_tready = 1'b0;
    endtask

    task automatic do_frame(input string tag, input logic [7:0] din[$], input bit use_last,
                            input logic [7:0] dexp[$]);
        logic [7:0] d;
        bit         l;
        foreach (din[i]) push(din[i], use_last && (i == din.size() - 1));
        chk({tag, "_rdy_lo"}, {31'd0, src_tready}, 32'd0);
        foreach (dexp[i]) begin
            chk({tag, "_rdy_drain"}, {31'd0, src_tready}, 32'd0);
            pull(d, l);
            chk({tag, "_data"}, {24'd0, d}, {24'd0, dexp[i]});
            chk({tag, "_last"}, {31'd0, l}, (i == dexp.size() - 1) ? 32'd1 : 32'd0);
        end
        chk({tag, "_rdy_hi"}, {31'd0, src_tready}, 32'd1);
    endtask

    initial begin
        logic [7:0] din[$];
        logic [7:0] dexp[$];
        logic [7:0] got[$];
        logic [7:0] held;
        logic [7:0] w[4];
        logic [7:0] s[4];
        logic [7:0] tmp;
        logic [31:0] pk;
        bit stalled;
        bit ok;
        bit l;

        // Reset state
        repeat (3) step();
        chk("rst_src_tready", {31'd0, src_tready}, 32'd0);
        chk("rst_dest_tvalid", {31'd0, dest_tvalid}, 32'd0);
        chk("rst_dest_tlast", {31'd0, dest_tlast}, 32'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, src_tready}, 32'd1);
        step();

        din = '{8'd4, 8'd3, 8'd2, 8'd1};     dexp = '{8'd1, 8'd2, 8'd3, 8'd4};
        do_frame("full", din, 1'b1, dexp);

        din = '{8'hFF, 8'h00, 8'h80, 8'h7F}; dexp = '{8'h00, 8'h7F, 8'h80, 8'hFF};
        do_frame("implicit", din, 1'b0, dexp);

        din = '{8'd5, 8'd5, 8'd2};           dexp = '{8'd2, 8'd5, 8'd5};
        do_frame("dup3", din, 1'b1, dexp);

        din = '{8'd9};                        dexp = '{8'd9};
        do_frame("single", din, 1'b1, dexp);

        // Backpressure: dest_tready alternates every cycle
        din = '{8'd3, 8'd1, 8'd2, 8'd0};
        foreach (din[i]) push(din[i], i == 3);
        got = {};
        stalled = 1'b0;
        held = '0;
        for (int c = 0; c < 300 && got.size() < 4; c++) begin
            dest_tready = c[0];
            if (dest_tvalid) begin
                if (stalled) chk("bp_stable", {24'd0, dest_tdata}, {24'd0, held});
                if (dest_tready) begin
                    got.push_back(dest_tdata);
                    chk("bp_last", {31'd0, dest_tlast}, (got.size() == 4) ? 32'd1 : 32'd0);
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = dest_tdata;
                end
            end
            step();
        end
        dest_tready = 1'b0;
        chk("bp_count", got.size(), 32'd4);
        dexp = '{8'd0, 8'd1, 8'd2, 8'd3};
        foreach (dexp[i]) chk("bp_data", (i < got.size()) ? {24'd0, got[i]} : 32'hDEAD, {24'd0, dexp[i]});
        chk("bp_rdy_hi", {31'd0, src_tready}, 32'd1);

        // Reset while sorting a reversed frame
        din = '{8'd7, 8'd6, 8'd5, 8'd4};
        foreach (din[i]) push(din[i], 1'b0);
        step();
        rst = 1'b0;
        step();
        chk("midrst_ready", {31'd0, src_tready}, 32'd0);
        chk("midrst_valid", {31'd0, dest_tvalid}, 32'd0);
        rst = 1'b1;
        dest_tready = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            if (dest_tvalid) ok = 1'b0;
            step();
        end
        dest_tready = 1'b0;
        chk("midrst_no_out", {31'd0, ok}, 32'd1);
        din = '{8'd2, 8'd1, 8'd4, 8'd3};     dexp = '{8'd1, 8'd2, 8'd3, 8'd4};
        do_frame("after_rst", din, 1'b1, dexp);

        // Random full frames packed LSB-first into 32 bits
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 4; i++) begin
                w[i] = 8'($urandom_range(0, 255));
                s[i] = w[i];
            end
            for (int i = 0; i < 3; i++)
                for (int j = i + 1; j < 4; j++)
                    if (s[j] < s[i]) begin
                        tmp = s[i]; s[i] = s[j]; s[j] = tmp;
                    end
            for (int i = 0; i < 4; i++) push(w[i], 1'b0);
            pk = '0;
            for (int i = 0; i < 4; i++) begin
                pull(tmp, l);
                pk[i*8 +: 8] = tmp;
            end
            ok = (pk[7:0] <= pk[15:8]) && (pk[15:8] <= pk[23:16]) && (pk[23:16] <= pk[31:24]);
            chk("rnd_order", {31'd0, ok}, 32'd1);
            chk("rnd_packed", pk, {s[3], s[2], s[1], s[0]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
